// File: rtl/snn_sched_pkg.sv
// -----------------------------------------------------------------------------
// snn_sched_pkg
// Shared definitions for the synaptic event scheduler and its arbiters:
//   - scheduler FSM state encodings (IDLE, ISSUE, GAP, REFRAC)
//   - clog2 constant function used for index and counter widths
//   - default widths shared with the wlif neuron
// No ports (package).
// -----------------------------------------------------------------------------
package snn_sched_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;
  localparam logic [1:0] ST_REFRAC = 2'd3;

  // Defaults matching the wlif neuron.
  localparam int SNN_NSYN  = 8;
  localparam int SNN_WIDTH = 8;

  // Ceiling log2, never less than 1 so that index vectors are always legal.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker: finds the first set request bit at or
// above rr_ptr, wrapping around past the top index.
// Ports:
//   pend      in  P_N   request bits
//   rr_ptr    in  IW    search start index
//   any_valid out 1     at least one request bit is set
//   winner    out IW    index of the selected request (0 when none)
// -----------------------------------------------------------------------------
module rr_picker
  import snn_sched_pkg::*;
#(
  parameter int P_N = SNN_NSYN,
  localparam int IW = clog2(P_N)
) (
  input  logic [P_N-1:0] pend,
  input  logic [IW-1:0]  rr_ptr,
  output logic           any_valid,
  output logic [IW-1:0]  winner
);

  always_comb begin
    int idx;
    idx       = 0;
    any_valid = |pend;
    winner    = '0;
    // Walk offsets from farthest to nearest so the nearest hit is the last
    // assignment and therefore the one that sticks.
    for (int k = P_N - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % P_N;
      if (pend[idx]) winner = IW'(idx);
    end
  end

endmodule

// File: rtl/syn_event_sched.sv
// -----------------------------------------------------------------------------
// syn_event_sched
// Per-neuron synaptic event scheduler for the wlif neuron. Latches presynaptic
// spike pulses as pending bits, grants them round-robin one at a time and
// drives the neuron's event/weight inputs from an internal weight file. A
// minimum inter-event gap follows every event and a refractory window follows
// every neuron fire (i_clr).
//
// Optional build macro SNN_REFRAC_FLUSH_EN: when defined, i_clr discards all
// pending spikes and incoming spikes are ignored while refractory. When
// undefined, pending spikes survive the refractory window.
//
// Ports:
//   i_clk      in  1       clock
//   i_rst      in  1       synchronous active-high reset
//   i_spike    in  P_NSYN  presynaptic spike pulses
//   i_wr_en    in  1       weight write strobe
//   i_wr_addr  in  IDW     weight write index
//   i_wr_data  in  P_WIDTH weight write value
//   i_clr      in  1       neuron fired/cleared (wlif o_clr)
//   o_event    out 1       one-cycle event pulse (wlif i_event)
//   o_weight   out P_WIDTH weight of granted synapse (wlif i_weight)
//   o_syn_id   out IDW     index of granted synapse
//   o_busy     out 1       pending work or FSM not idle
//   o_drop     out 1       spike hit an already-pending synapse
// -----------------------------------------------------------------------------
module syn_event_sched
  import snn_sched_pkg::*;
#(
  parameter int P_NSYN   = SNN_NSYN,
  parameter int P_WIDTH  = SNN_WIDTH,
  parameter int P_GAP    = 2,
  parameter int P_REFRAC = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [P_NSYN-1:0]          i_spike,
  input  logic                       i_wr_en,
  input  logic [clog2(P_NSYN)-1:0]   i_wr_addr,
  input  logic [P_WIDTH-1:0]         i_wr_data,
  input  logic                       i_clr,
  output logic                       o_event,
  output logic [P_WIDTH-1:0]         o_weight,
  output logic [clog2(P_NSYN)-1:0]   o_syn_id,
  output logic                       o_busy,
  output logic                       o_drop
);

  localparam int IDW  = clog2(P_NSYN);
  localparam int CMAX = (P_GAP > P_REFRAC) ? P_GAP : P_REFRAC;
  localparam int CW   = clog2(CMAX + 1);

  logic [1:0]         state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [P_NSYN-1:0]  pend_reg;
  logic [P_NSYN-1:0]  pend_next;
  logic [P_NSYN-1:0]  issue_mask;
  logic [P_NSYN-1:0]  spike_eff;
  logic [IDW-1:0]     rr_ptr_reg;
  logic [IDW-1:0]     syn_id_reg;
  logic [IDW-1:0]     winner;
  logic [P_WIDTH-1:0] weight_reg;
  logic [P_WIDTH-1:0] wmem [P_NSYN];
  logic               any_valid;
  logic               grant;
  logic               clr_take;
  logic               drop_reg;

  rr_picker #(.P_N(P_NSYN)) u_picker (
    .pend      (pend_reg),
    .rr_ptr    (rr_ptr_reg),
    .any_valid (any_valid),
    .winner    (winner)
  );

  // A zero-length refractory window means the fire signal has no effect.
  assign clr_take = (P_REFRAC > 0) ? i_clr : 1'b0;

  // A fire cancels the grant that IDLE would otherwise make this cycle.
  assign grant = (state_reg == ST_IDLE) && any_valid && !clr_take;

  // The bit being issued is the one latched at grant time.
  always_comb begin
    issue_mask = '0;
    if (state_reg == ST_ISSUE) issue_mask[syn_id_reg] = 1'b1;
  end

`ifdef SNN_REFRAC_FLUSH_EN
  assign spike_eff = (clr_take || (state_reg == ST_REFRAC)) ? '0 : i_spike;
`else
  assign spike_eff = i_spike;
`endif

  // New spikes are OR-ed in after the issue clear, so a spike wins over a
  // same-cycle issue of the same synapse.
  always_comb begin
    pend_next = (pend_reg & ~issue_mask) | spike_eff;
`ifdef SNN_REFRAC_FLUSH_EN
    if (clr_take) pend_next = '0;
`endif
  end

  // Weight file; a grant reads the value held before any same-edge write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < P_NSYN; i++) wmem[i] <= '0;
    end else if (i_wr_en) begin
      wmem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      pend_reg   <= '0;
      rr_ptr_reg <= '0;
      syn_id_reg <= '0;
      weight_reg <= '0;
      drop_reg   <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      drop_reg <= |(spike_eff & pend_reg & ~issue_mask);

      if (grant) begin
        syn_id_reg <= winner;
        weight_reg <= wmem[winner];
        rr_ptr_reg <= (winner == IDW'(P_NSYN - 1)) ? '0 : winner + IDW'(1);
      end

      if (clr_take) begin
        // Entering or restarting the refractory window from any state.
        state_reg <= ST_REFRAC;
        cnt_reg   <= CW'(P_REFRAC - 1);
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (any_valid) state_reg <= ST_ISSUE;
          end
          ST_ISSUE: begin
            if (P_GAP == 0) begin
              state_reg <= ST_IDLE;
            end else begin
              state_reg <= ST_GAP;
              cnt_reg   <= CW'(P_GAP - 1);
            end
          end
          ST_GAP, ST_REFRAC: begin
            if (cnt_reg == '0) state_reg <= ST_IDLE;
            else               cnt_reg   <= cnt_reg - CW'(1);
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_event  = (state_reg == ST_ISSUE);
  assign o_weight = weight_reg;
  assign o_syn_id = syn_id_reg;
  assign o_drop   = drop_reg;
  assign o_busy   = (pend_reg != '0) || (state_reg != ST_IDLE);

endmodule

// File: doc/syn_event_sched.md
Name: syn_event_sched

Overview:
- Per-neuron synaptic event scheduler for the wlif neuron.
- Collects one-cycle presynaptic spike pulses from P_NSYN synapses and holds them as pending bits.
- Grants pending synapses round-robin, one at a time, and drives the neuron's event and weight inputs from an internal weight register file.
- Enforces a minimum inter-event gap and a post-fire refractory window taken from the neuron's clear/fire output.

Parameters:
- P_NSYN, 8, number of presynaptic inputs scheduled onto one neuron.
- P_WIDTH, 8, weight width; matches wlif p_width.
- P_GAP, 2, idle cycles inserted after each issued event (0 allowed).
- P_REFRAC, 4, refractory cycles after i_clr (0 means i_clr is ignored).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_spike  in  P_NSYN  presynaptic spike pulses, one bit per synapse.
- i_wr_en  in  1  weight write strobe.
- i_wr_addr  in  clog2(P_NSYN)  weight write index.
- i_wr_data  in  P_WIDTH  weight write value.
- i_clr  in  1  neuron fired/cleared; connect to wlif o_clr.
- o_event  out  1  one-cycle event pulse; connect to wlif i_event.
- o_weight  out  P_WIDTH  weight of the granted synapse; connect to wlif i_weight.
- o_syn_id  out  clog2(P_NSYN)  index of the granted synapse.
- o_busy  out  1  high when any bit is pending or the FSM is not in IDLE.
- o_drop  out  1  one-cycle pulse when a spike hits an already-pending synapse.

Behaviour:
- Single clock domain: i_clk, with i_rst synchronous and active-high.
- Reset: pend=0, rr_ptr=0, all weights=0, state=IDLE, all outputs 0. A reset mid-operation cancels any in-flight event; no o_event is produced after reset.
- Pending update: pend_next = (pend & ~issue_mask) | i_spike. A new spike wins over a same-cycle clear.
- o_drop = |(i_spike & pend & ~issue_mask), registered.
- Weight file: P_NSYN x P_WIDTH registers.
  - Write takes effect at the clock edge.
  - A grant in the same cycle as a write to the same index reads the old value.
- Round-robin grant: search from rr_ptr upward with wrap-around for the first set pending bit. After a grant, rr_ptr = winner+1 mod P_NSYN.
- FSM states and transitions:
  - IDLE: if pend!=0, pick the winner, register o_syn_id/o_weight, go to ISSUE.
  - ISSUE: o_event=1 for exactly one cycle and the winner's pend bit is cleared. Next state is GAP with cnt=P_GAP-1, or IDLE if P_GAP=0.
  - GAP: decrement cnt; at 0, go to IDLE.
  - REFRAC: decrement cnt; at 0, go to IDLE. Spikes still accumulate in pend.
- i_clr handling:
  - In any state, i_clr=1 with P_REFRAC>0 sends the FSM to REFRAC with cnt=P_REFRAC-1.
  - In ISSUE, the event pulse still completes that cycle.
  - In REFRAC, i_clr restarts the counter.
- Latency: spike at cycle t → pend set at edge t → o_event high in cycle t+2 when IDLE.
- Event spacing under backlog: P_GAP+2 cycles between rising edges of o_event.
- o_weight/o_syn_id are stable from the ISSUE cycle until the next grant. They are not cleared between events.
- o_busy is combinational: (pend!=0) | (state!=IDLE).

Optional Feature:
- Macro SNN_REFRAC_FLUSH_EN.
- Defined: on i_clr, all pend bits are cleared, and i_spike is masked (not latched, no o_drop) while in REFRAC.
- Undefined: pending spikes are retained through REFRAC and issued afterwards in round-robin order.

Decomposition:
- Shared package/include snn_sched_pkg:
  - FSM state encodings (IDLE, ISSUE, GAP, REFRAC).
  - clog2 constant function.
  - Default width constants shared with wlif.
- Sub-module rr_picker: combinational, takes pend and rr_ptr, returns any_valid and winner index. Reusable by other arbiters in the design.

Test Plan:
- Reset, write w[3]=0xA4, spike syn3 at cycle 0 → o_event in cycle 2, o_weight=0xA4, o_syn_id=3, o_busy low by cycle 5.
- w[1]=0x10, w[5]=0xF4, w[6]=0x3F; spikes 1,5,6 in the same cycle → events for ids 1,5,6 with weights 0x10,0xF4,0x3F, 4 cycles apart.
- Syn 0 and 7 spiking every cycle → grants alternate 0,7,0,7; o_drop pulses on repeated hits; no starvation.
- Spike syn2, then syn2 again while pending → one o_drop pulse, exactly one event for syn2.
- i_clr during GAP with syn4 pending → no o_event for 4 cycles.
  - Without macro: syn4 event follows REFRAC.
  - With SNN_REFRAC_FLUSH_EN: no syn4 event, o_busy low after REFRAC.
- i_rst asserted mid-GAP with 3 bits pending → next cycle all outputs 0 and pend=0; weights reset to 0; no further events.
